// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester.
// Contents: FSM state type, default bus widths and timeout, and the
// width helper for the ACCESS wait counter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH     = 10;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Counter must hold values 0..t; at least one bit even when the timeout is off.
    function automatic int unsigned wait_cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Clearable, saturating counter of ACCESS cycles spent with PREADY low.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - zero the counter (start of a new transfer)
//   inc          - one more wait cycle this clock
//   timeout_hit  - this increment makes the count reach TIMEOUT_CYCLES
//                  (never asserted when TIMEOUT_CYCLES is 0)
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic timeout_hit
);

    localparam int unsigned CNT_WIDTH = wait_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Flag is raised on the increment that would reach the limit, so the
    // abort lands on the same edge the count gets there.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && inc && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer and
// returns a single-cycle completion pulse.
// Ports:
//   PCLK, PRESETn                     - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               - command handshake
//   cmd_write, cmd_addr, cmd_wdata    - command fields (latched on handshake)
//   rsp_valid, rsp_rdata, rsp_err,
//   rsp_timeout                       - completion result
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA                            - APB requester outputs (all registered)
//   PRDATA, PREADY, PSLVERR           - APB completer inputs
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e state;
    logic       handshake;
    logic       wait_inc;
    logic       timeout_hit;

    assign handshake = (state == IDLE) && cmd_valid && cmd_ready;
    assign wait_inc  = (state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .clear      (handshake),
        .inc        (wait_inc),
        .timeout_hit(timeout_hit)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (handshake) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_write ? cmd_wdata : '0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout reached on the same edge.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        if (!PWRITE) begin
                            rsp_rdata <= PRDATA;
                        end
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the PWDATA, PRDATA, cmd_wdata and rsp_rdata buses.
REQ-002 Parameter ADDR_WIDTH, default 10, width of the PADDR and cmd_addr buses.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.
REQ-004 Port PCLK, input, 1, the single clock; all logic is on the rising edge.
REQ-005 Port PRESETn, input, 1; reset is asynchronous and active-low.
REQ-006 Port cmd_valid, input, 1, a command is offered.
REQ-007 Port cmd_ready, output, 1, the block accepts a command this cycle.
REQ-008 Ports cmd_write (input, 1), cmd_addr (input, ADDR_WIDTH) and cmd_wdata (input, DATA_WIDTH) carry the command fields.
REQ-009 Port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-010 Ports rsp_rdata (output, DATA_WIDTH), rsp_err (output, 1) and rsp_timeout (output, 1) carry the completion result.
REQ-011 Ports PSEL, PENABLE and PWRITE (output, 1 each), PADDR (output, ADDR_WIDTH) and PWDATA (output, DATA_WIDTH) form the APB requester outputs.
REQ-012 Ports PRDATA (input, DATA_WIDTH), PREADY (input, 1) and PSLVERR (input, 1) form the APB completer inputs.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-014 cmd_ready SHALL be 1 only in IDLE.
REQ-015 A handshake occurs when cmd_valid and cmd_ready are both 1 at a clock edge.
- On a handshake the block SHALL latch cmd_write, cmd_addr and cmd_wdata.
- It SHALL then enter SETUP with PSEL=1 and PENABLE=0.
REQ-016 Command inputs SHALL be ignored outside a handshake.
REQ-017 SETUP SHALL last exactly one cycle, then go to ACCESS with PSEL=1 and PENABLE=1.
REQ-018 PADDR, PWRITE and PWDATA SHALL stay constant from SETUP through the last ACCESS cycle.
REQ-019 PWDATA SHALL be 0 for reads.
REQ-020 If PREADY=1 is sampled in ACCESS:
- The next cycle SHALL have PSEL=0, PENABLE=0 and state IDLE.
- rsp_valid SHALL be 1 for that one cycle, with rsp_err=PSLVERR and rsp_timeout=0.
- For a read, rsp_rdata SHALL equal the PRDATA sampled; for a write, rsp_rdata SHALL hold its previous value.
REQ-021 Each cycle in ACCESS with PREADY=0 SHALL increment a wait counter; the counter SHALL be cleared on entry to SETUP.
REQ-022 If TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES, the block SHALL abort the transfer.
- It SHALL deassert PSEL and PENABLE.
- It SHALL pulse rsp_valid with rsp_err=1 and rsp_timeout=1, leave rsp_rdata unchanged, and return to IDLE.
REQ-023 If PREADY=1 arrives in the same cycle the count would reach TIMEOUT_CYCLES, the transfer SHALL complete normally, with no timeout.
REQ-024 The minimum transfer time is 3 cycles from handshake to rsp_valid: SETUP, one ACCESS cycle, then response.
- The next handshake SHALL be possible in the rsp_valid cycle, since IDLE is already re-entered.
REQ-025 The wait counter width SHALL be clog2(TIMEOUT_CYCLES+1), with a minimum of 1, and it SHALL saturate rather than wrap.
REQ-026 PSLVERR and PRDATA SHALL be ignored unless PREADY=1 in ACCESS.

Reset
REQ-027 While PRESETn=0, the state SHALL be IDLE.
- PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_timeout and rsp_rdata SHALL be 0, and cmd_ready SHALL be 1.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no rsp_valid generated.
- After release, the block SHALL accept a new command in the first cycle.

Structure
REQ-029 A shared package apb_pkg SHALL hold:
- the FSM state enum (IDLE/SETUP/ACCESS);
- the default DATA_WIDTH and ADDR_WIDTH constants;
- the default TIMEOUT_CYCLES constant.
REQ-030 One sub-module, apb_wait_timer, SHALL implement the clearable, saturating wait counter and its timeout flag; all other logic SHALL live in apb_master.

Verification
REQ-031 Write with no wait: cmd write addr 0x004, data 0xDEADBEEF, PREADY=1 in the first ACCESS cycle -> PSEL high 2 cycles, PENABLE high 1 cycle, rsp_valid 3 cycles after the handshake, rsp_err=0.
REQ-032 Read with 1 wait state: addr 0x010, PREADY low 1 cycle then high with PRDATA=0x12345678 -> rsp_rdata=0x12345678, rsp_valid 4 cycles after the handshake, PADDR stable throughout.
REQ-033 Slave error: read with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-034 Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0.
- A new command is then accepted.
REQ-035 Back-to-back: cmd_valid held high with two commands -> the second handshake occurs in the first command's rsp_valid cycle, and the SETUP phases of the two transfers are 3 cycles apart.
REQ-036 Reset in ACCESS: PRESETn low during a wait state -> PSEL and PENABLE are 0 immediately, no rsp_valid, and a command issued after release completes normally.
